prog_loader: RTL and testbench

//  Byte-stream program loader: the writer side of the CPU instruction-memory load port (instr/we).

---
 rtl/prog_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_prog_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Byte-stream program loader. This is the writer side of a CPU
// instruction-memory load port. A framed stream has three parts:
//   - a one-byte word-count header N (N = 0 means a full program);
//   - N big-endian 16-bit instructions;
//   - an optional one-byte mod-256 checksum of every byte after the header.
// Each instruction is written with a single o_we strobe. Writes go to
// consecutive addresses starting at 0. The CPU is held in reset for the whole
// load, and also after a failed load.
//
// Build option:
//   PROG_LOADER_CHECKSUM_EN  when defined, a trailing checksum byte is checked
//                            after the last write. A mismatch ends in ERR.
//                            When undefined, there is no checksum logic and
//                            o_err is tied low.
//
// Parameters:
//   ADDR_W        instruction address width (program length up to 2**ADDR_W)
//
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   i_rst         synchronous active-high reset
//   i_start       1-cycle pulse that begins or restarts a load
//   i_byte        incoming stream byte
//   i_byte_valid  i_byte is valid; it is consumed only when o_ready = 1
//   o_ready       loader accepts a byte this cycle (HDR, HI, LO, CHK)
//   o_instr       assembled instruction, to the CPU instruction input
//   o_addr        write address for o_instr
//   o_we          1-cycle write strobe, to the CPU write enable
//   o_cpu_rst     CPU reset request; high while loading or in error
//   o_busy        load in progress
//   o_done        level: the last load completed successfully
//   o_err         level: the last load failed its checksum
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  output logic              o_ready,
  output logic [15:0]       o_instr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_we,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HI,
    S_LO,
    S_WR,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

  // The header is only 8 bits wide, so a program never exceeds 256 words.
  // A zero header therefore means 2**ADDR_W words, capped at 256.
  localparam logic [8:0] FULL_CNT = (ADDR_W >= 8) ? 9'd256 : 9'(2 ** ADDR_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;        // next write address
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;  // address presented on o_addr
  logic [8:0]          cnt_q, cnt_d;          // words still to be written
  logic [15:0]         instr_q, instr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  logic byte_acc;

  assign byte_acc = o_ready && i_byte_valid;
  assign o_instr  = instr_q;
  assign o_addr   = wr_addr_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      instr_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore: outputs depend on the registered state only)
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case statement, so no path
  // through the block can leave a latch behind.
  always_comb begin
    o_ready   = 1'b0;
    o_busy    = 1'b0;
    o_we      = 1'b0;
    o_cpu_rst = 1'b0;
    o_done    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    o_err     = 1'b0;
`endif
    unique case (state_q)
      S_HDR, S_HI, S_LO: begin
        o_ready   = 1'b1;
        o_busy    = 1'b1;
        o_cpu_rst = 1'b1;
      end
      S_WR: begin
        o_we      = 1'b1;
        o_busy    = 1'b1;
        o_cpu_rst = 1'b1;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        o_ready   = 1'b1;
        o_busy    = 1'b1;
        o_cpu_rst = 1'b1;
      end
`endif
      S_DONE: o_done = 1'b1;
      S_ERR: begin
        o_cpu_rst = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        o_err     = 1'b1;
`endif
      end
      default: ;
    endcase
  end

`ifndef PROG_LOADER_CHECKSUM_EN
  assign o_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    if (i_start) begin
      // A start in any state wins over a byte accepted in the same cycle.
      // The load restarts from address 0.
      state_d = S_HDR;
      addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end else begin
      unique case (state_q)
        S_HDR: if (byte_acc) begin
          cnt_d   = (i_byte == 8'd0) ? FULL_CNT : {1'b0, i_byte};
          state_d = S_HI;
        end
        S_HI: if (byte_acc) begin
          instr_d[15:8] = i_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d         = sum_q + i_byte;
`endif
          state_d       = S_LO;
        end
        S_LO: if (byte_acc) begin
          instr_d[7:0] = i_byte;
          // Latch the target address now, so o_addr stays stable through WR
          // and holds its value afterwards while addr_q moves on.
          wr_addr_d    = addr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d        = sum_q + i_byte;
`endif
          state_d      = S_WR;
        end
        S_WR: begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_HI;
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: if (byte_acc) begin
          state_d = (i_byte == sum_q) ? S_DONE : S_ERR;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Directed testbench for prog_loader with ADDR_W = 8. Inputs are driven 1 ns
// after each rising edge, and outputs are checked at that same point. A
// negedge monitor records every write strobe as {addr, instr}. Tests that
// need the checksum byte follow the PROG_LOADER_CHECKSUM_EN define.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              ready;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] wr_q[$];

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_byte      (byte_in),
    .i_byte_valid(byte_valid),
    .o_ready     (ready),
    .o_instr     (instr),
    .o_addr      (addr),
    .o_we        (we),
    .o_cpu_rst   (cpu_rst),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  // Write monitor: samples away from the active edge.
  always @(negedge clk) begin
    if (we) wr_q.push_back({addr, instr});
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and hold it until it has been accepted exactly once.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    if (!ready) check("ready_wait", {31'd0, ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int bad;
    rst        = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;

    // ---- T1: reset ----------------------------------------------------------
    tick();
    tick();
    check("rst_ready",   {31'd0, ready},   32'd0);
    check("rst_flags",   {27'd0, we, cpu_rst, busy, done, err}, 32'd0);
    check("rst_instr",   {16'd0, instr},   32'd0);
    check("rst_addr",    {24'd0, addr},    32'd0);
    rst = 1'b0;
    // A byte presented while idle must be ignored.
    byte_in = 8'h55; byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    check("idle_ignore", {29'd0, ready, busy, cpu_rst}, 32'd0);

    // ---- T2/T3: two-word load with a byte presented during WR ---------------
    pulse_start();
    check("hdr_flags", {29'd0, ready, busy, cpu_rst}, 32'h7);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    // Now in WR. Present AB; it must not be taken this cycle.
    byte_in = 8'hAB; byte_valid = 1'b1;
    check("wr0_we",    {31'd0, we},    32'd1);
    check("wr0_ready", {31'd0, ready}, 32'd0);
    check("wr0_data",  {8'd0, addr, instr}, 32'h00_1234);
    tick();
    check("hi_ready",  {30'd0, ready, we}, 32'h2);
    tick();
    byte_valid = 1'b0;
    check("hi_byte",   {24'd0, instr[15:8]}, 32'hAB);
    send(8'hCD);
    check("wr1_data",  {7'd0, we, addr, instr}, 32'h1_01_ABCD);
`ifdef PROG_LOADER_CHECKSUM_EN
    // 12 + 34 + AB + CD = 1BE, so the checksum is BE.
    send(8'hBE);
`else
    tick();
`endif
    check("t2_end",    {28'd0, done, cpu_rst, busy, err}, 32'h8);
    check("t2_hold",   {8'd0, addr, instr}, 32'h01_ABCD);
    check("t2_nwr",    wr_q.size(), 32'd2);
    if (wr_q.size() == 2) begin
      check("t2_w0", {8'd0, wr_q[0]}, 32'h00_1234);
      check("t2_w1", {8'd0, wr_q[1]}, 32'h01_ABCD);
    end
    tick();
    check("done_stays", {31'd0, done}, 32'd1);

    // ---- T4: full 256-word load, addresses 00..FF ---------------------------
    wr_q.delete();
    pulse_start();
    check("restart_done", {31'd0, done}, 32'd0);
    send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      send(~8'(i));
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    // Each word contributes i + ~i = FF; 256 * FF mod 256 = 00.
    send(8'h00);
`else
    tick();
`endif
    check("full_done", {31'd0, done}, 32'd1);
    check("full_nwr",  wr_q.size(), 32'd256);
    bad = 0;
    for (int i = 0; i < wr_q.size() && i < 256; i++) begin
      if (wr_q[i] !== {8'(i), 8'(i), ~8'(i)}) bad++;
    end
    check("full_data", bad, 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // ---- T5: checksum mismatch, then match ----------------------------------
    pulse_start();
    send(8'h01); send(8'h00); send(8'h05);
    send(8'h06);
    check("chk_bad", {28'd0, err, cpu_rst, done, busy}, 32'hC);
    tick();
    check("err_stays", {31'd0, err}, 32'd1);
    pulse_start();
    check("err_clear", {31'd0, err}, 32'd0);
    send(8'h01); send(8'h00); send(8'h05);
    send(8'h05);
    check("chk_good", {28'd0, err, cpu_rst, done, busy}, 32'h2);
`endif

    // ---- T6: abort via start, then reset mid-load ---------------------------
    wr_q.delete();
    pulse_start();
    send(8'h02); send(8'h11); send(8'h22);
    tick();  // WR completes, now in HI
    // Start together with a valid byte: the byte must be discarded.
    byte_in = 8'h33; byte_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0; byte_valid = 1'b0;
    check("abort_hdr", {28'd0, ready, busy, we, done}, 32'hC);
    send(8'h01); send(8'hFF); send(8'h00);
    check("abort_wr", {7'd0, we, addr, instr}, 32'h1_00_FF00);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'hFF);
`else
    tick();
`endif
    check("abort_done", {31'd0, done}, 32'd1);
    check("abort_nwr",  wr_q.size(), 32'd2);
    if (wr_q.size() == 2) begin
      check("abort_w0", {8'd0, wr_q[0]}, 32'h00_1122);
      check("abort_w1", {8'd0, wr_q[1]}, 32'h00_FF00);
    end

    pulse_start();
    send(8'h03); send(8'h44);
    check("mid_busy", {30'd0, busy, cpu_rst}, 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst", {27'd0, cpu_rst, busy, ready, done, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
